// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and bit-period helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Clock cycles per serial bit (floor), shared with the transmitter side.
    function automatic int bit_period(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_receive_if.sv
// Receiver-side bundle: serial line in, received byte and status pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; new_data_out is a one-cycle pulse the consumer must take.
//   rx_wire_in         serial line (idles high)
//   data_byte_out      last correctly framed byte
//   new_data_out       1-cycle pulse, data_byte_out updated
//   framing_error_out  1-cycle pulse, stop bit was low
//   busy_out           receiver not in IDLE
interface uart_receive_if;
    import uart_pkg::*;

    logic                      rx_wire_in;
    logic [UART_DATA_BITS-1:0] data_byte_out;
    logic                      new_data_out;
    logic                      framing_error_out;
    logic                      busy_out;

    // master: the receiver that produces the byte stream
    modport master (
        input  rx_wire_in,
        output data_byte_out,
        output new_data_out,
        output framing_error_out,
        output busy_out
    );

    // slave: the line driver / downstream consumer
    modport slave (
        output rx_wire_in,
        input  data_byte_out,
        input  new_data_out,
        input  framing_error_out,
        input  busy_out
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width and reset value.
// Latency: 2 clk_in cycles.
// Backpressure: none.
//   clk_in, rst_in (async, active-high), d_in (async), q_out (synchronized)
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver, LSB first: start qualified at mid-bit, data/stop sampled at bit centres.
// Latency: new_data_out 2 + HALF + 9*BIT_PERIOD + 1 cycles after the start edge at the pin.
// Backpressure: none; each byte is a one-cycle pulse, the consumer must accept it.
//   clk_in, rst_in (async, active-high); rx_if (uart_receive_if.master): rx_wire_in in,
//   data_byte_out / new_data_out / framing_error_out / busy_out out.
//   UART_RX_GLITCH_FILTER_EN: majority-of-three vote at every sample point.
module uart_receive
    import uart_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 57600
) (
    input  logic           clk_in,
    input  logic           rst_in,
    uart_receive_if.master rx_if
);

    localparam int BIT_PERIOD = bit_period(INPUT_CLOCK_FREQ, BAUD_RATE);
    localparam int HALF       = BIT_PERIOD / 2;
    localparam int CW         = $clog2(BIT_PERIOD + 1);

    localparam logic [CW-1:0] HALF_LIM = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LIM  = CW'(BIT_PERIOD - 1);

    rx_state_t                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      new_data_q, new_data_d;
    logic                      ferr_q, ferr_d;

    logic rx_sync;
    logic sample;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (rx_if.rx_wire_in),
        .q_out  (rx_sync)
    );

`ifdef UART_RX_GLITCH_FILTER_EN
    // The vote combines the current synchronized value with the two before it,
    // so the decision lands on the same cycle as the unfiltered sample.
    logic hist1_q, hist1_d;
    logic hist2_q, hist2_d;

    always_comb begin
        hist1_d = rx_sync;
        hist2_d = hist1_q;
        sample  = (rx_sync & hist1_q) | (rx_sync & hist2_q) | (hist1_q & hist2_q);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
        end
    end
`else
    always_comb begin
        sample = rx_sync;
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        new_data_d = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_sync) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LIM) begin
                    cnt_d = '0;
                    // A line back high at mid start bit was only a glitch.
                    if (sample) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LIM) begin
                    cnt_d     = '0;
                    shift_d   = {sample, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LIM) begin
                    cnt_d = '0;
                    // Leaving at the stop-bit centre lets a back-to-back start edge be seen.
                    if (sample) begin
                        data_d     = shift_q;
                        new_data_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low (break) line must release before another start is accepted.
                cnt_d = '0;
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= '0;
            data_q     <= '0;
            new_data_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            new_data_q <= new_data_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_if.data_byte_out     = data_q;
    assign rx_if.new_data_out      = new_data_q;
    assign rx_if.framing_error_out = ferr_q;
    assign rx_if.busy_out          = (state_q != IDLE);

endmodule
